// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Imported by the arbiter top and its wait counter.
package dmem_pkg;

  typedef enum logic [0:0] {
    CORE_PRI   = 1'b0,
    HOST_FORCE = 1'b1
  } arb_state_e;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam int         RD_LAT  = 1;

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating host wait counter; sat flags that the
// next-cycle count has reached the bound.
module starve_counter
  import dmem_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX =
    CNT_W'(HOST_MAX_WAIT);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && (cnt != MAX))
      cnt_nxt = cnt + CNT_W'(1);
  end

  assign sat = (cnt_nxt == MAX);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core-priority arbiter for BRAM port B with a bounded
// host wait and one-cycle read-data return routing.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 8,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [3:0]  host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e       state, state_nxt;
  logic             core_grant, host_grant;
  logic             cnt_inc, cnt_clr, cnt_sat;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic             rd_core, rd_host;
  logic             core_hit, host_hit;
  logic [31:0]      core_rdata_q, host_rdata_q;

  always_comb begin
    core_grant = 1'b0;
    host_grant = 1'b0;
    state_nxt  = state;
    unique case (state)
      CORE_PRI: begin
        core_grant = core_req;
        host_grant = ~core_req & host_valid;
        if (cnt_sat)
          state_nxt = HOST_FORCE;
      end
      HOST_FORCE: begin
        host_grant = host_valid;
        core_grant = core_req & ~host_valid;
        state_nxt  = CORE_PRI;
      end
      default: state_nxt = CORE_PRI;
    endcase
    if (rst) begin
      core_grant = 1'b0;
      host_grant = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= CORE_PRI;
    else
      state <= state_nxt;
  end

  assign cnt_inc = host_valid & ~host_grant;
  assign cnt_clr = host_grant | ~host_valid;

  starve_counter #(
    .HOST_MAX_WAIT (HOST_MAX_WAIT),
    .CNT_W         (CNT_W)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .cnt     (wcnt),
    .cnt_nxt (wcnt_nxt),
    .sat     (cnt_sat)
  );

  always_comb begin
    mem_we    = WE_NONE;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    unique case (1'b1)
      core_grant: mem_we = core_we;
      host_grant: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & ~core_grant;
  assign host_ready = host_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_core <= 1'b0;
      rd_host <= 1'b0;
    end else begin
      rd_core <= core_grant & (core_we == WE_NONE);
      rd_host <= host_grant & (host_we == WE_NONE);
    end
  end

  // Hold last returned word so rdata stays stable between pulses.
  assign core_hit = rd_core & ~rst;
  assign host_hit = rd_host & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (core_hit)
        core_rdata_q <= mem_rdata;
      if (host_hit)
        host_rdata_q <= mem_rdata;
    end
  end

  assign core_rvalid = core_hit;
  assign host_rvalid = host_hit;
  assign core_rdata  = core_hit ? mem_rdata : core_rdata_q;
  assign host_rdata  = host_hit ? mem_rdata : host_rdata_q;

  host_hold_a: assert property (
    @(posedge clk) disable iff (rst)
    (host_valid && !host_ready) |=>
      (host_valid && $stable(host_addr) &&
       $stable(host_we) && $stable(host_wdata))
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a BRAM model.
// Grant table plus multi-cycle corner sequences.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [3:0]  core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        host_valid, host_ready;
  logic [3:0]  host_we;
  logic [31:0] host_addr, host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bram [0:255];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.HOST_MAX_WAIT(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      bram[4]  <= 32'hDEADBEEF;
      bram[8]  <= 32'h0;
      bram[16] <= 32'h0;
      bram[20] <= 32'h11223344;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i])
          bram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_rdata <= bram[mem_addr[9:2]];
  end

  typedef struct {
    logic        c_req;
    logic [3:0]  c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        h_valid;
    logic [3:0]  h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        e_stall;
    logic        e_ready;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req   = 1'b0;
    core_we    = 4'h0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    host_valid = 1'b0;
    host_we    = 4'h0;
    host_addr  = 32'h0;
    host_wdata = 32'h0;
  endtask

  int waited, early_stall;
  logic granted;

  initial begin
    vecs[0] = '{1'b0, 4'h0, 32'h100, 32'h1, 1'b0, 4'h0,
                32'h200, 32'h2, 1'b0, 1'b0, 4'h0, 32'h100, 32'h1};
    vecs[1] = '{1'b1, 4'h0, 32'h104, 32'h3, 1'b0, 4'h0,
                32'h200, 32'h4, 1'b0, 1'b0, 4'h0, 32'h104, 32'h3};
    vecs[2] = '{1'b1, 4'hF, 32'h108, 32'h5, 1'b0, 4'h0,
                32'h200, 32'h6, 1'b0, 1'b0, 4'hF, 32'h108, 32'h5};
    vecs[3] = '{1'b0, 4'h0, 32'h10C, 32'h7, 1'b1, 4'h3,
                32'h200, 32'h8, 1'b0, 1'b1, 4'h3, 32'h200, 32'h8};
    vecs[4] = '{1'b1, 4'h1, 32'h110, 32'h9, 1'b1, 4'hF,
                32'h204, 32'hA, 1'b0, 1'b0, 4'h1, 32'h110, 32'h9};
    vecs[5] = '{1'b0, 4'h0, 32'h114, 32'hB, 1'b1, 4'h0,
                32'h208, 32'hC, 1'b0, 1'b1, 4'h0, 32'h208, 32'hC};

    idle_inputs();
    rst        = 1'b1;
    core_req   = 1'b1;
    core_we    = 4'hF;
    host_valid = 1'b1;
    host_we    = 4'hF;
    #1;
    check("rst_core_stall", 32'(core_stall), 32'd1);
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    tick();
    check("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    // All table vectors are applied between two clock edges.
    for (int i = 0; i < 6; i++) begin
      core_req   = vecs[i].c_req;
      core_we    = vecs[i].c_we;
      core_addr  = vecs[i].c_addr;
      core_wdata = vecs[i].c_wdata;
      host_valid = vecs[i].h_valid;
      host_we    = vecs[i].h_we;
      host_addr  = vecs[i].h_addr;
      host_wdata = vecs[i].h_wdata;
      #1;
      check($sformatf("v%0d_stall", i), 32'(core_stall),
            32'(vecs[i].e_stall));
      check($sformatf("v%0d_ready", i), 32'(host_ready),
            32'(vecs[i].e_ready));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we),
            32'(vecs[i].e_we));
      check($sformatf("v%0d_mem_addr", i), mem_addr,
            vecs[i].e_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,
            vecs[i].e_wdata);
    end
    idle_inputs();
    tick();

    core_req  = 1'b1;
    core_addr = 32'h10;
    #1;
    check("core_rd_stall", 32'(core_stall), 32'd0);
    tick();
    core_req = 1'b0;
    check("core_rd_rvalid", 32'(core_rvalid), 32'd1);
    check("core_rd_rdata", core_rdata, 32'hDEADBEEF);
    check("core_rd_hrvalid", 32'(host_rvalid), 32'd0);
    tick();
    check("core_rd_rvalid_end", 32'(core_rvalid), 32'd0);

    host_valid = 1'b1;
    host_we    = 4'hF;
    host_addr  = 32'h20;
    host_wdata = 32'h12345678;
    #1;
    check("host_wr_ready", 32'(host_ready), 32'd1);
    tick();
    host_we = 4'h0;
    #1;
    check("host_rd_ready", 32'(host_ready), 32'd1);
    check("host_wr_no_rvalid", 32'(host_rvalid), 32'd0);
    tick();
    host_valid = 1'b0;
    check("host_rd_rvalid", 32'(host_rvalid), 32'd1);
    check("host_rd_rdata", host_rdata, 32'h12345678);
    check("host_rd_crvalid", 32'(core_rvalid), 32'd0);
    tick();

    core_req   = 1'b1;
    core_we    = 4'h0;
    core_addr  = 32'h40;
    host_valid = 1'b1;
    host_we    = 4'hF;
    host_addr  = 32'h40;
    host_wdata = 32'hAAAA5555;
    waited      = 0;
    early_stall = 0;
    granted     = 1'b0;
    for (int c = 1; c <= 20 && !granted; c++) begin
      #1;
      if (host_ready) begin
        granted = 1'b1;
        waited  = c;
        check("force_core_stall", 32'(core_stall), 32'd1);
        check("force_mem_we", 32'(mem_we), 32'hF);
      end else if (core_stall) begin
        early_stall++;
      end
      tick();
    end
    host_valid = 1'b0;
    check("force_granted", 32'(granted), 32'd1);
    check("force_wait_cycles", 32'(waited), 32'd9);
    check("force_early_stalls", 32'(early_stall), 32'd0);
    #1;
    check("after_force_stall", 32'(core_stall), 32'd0);
    check("after_force_rvalid", 32'(core_rvalid), 32'd0);
    check("after_force_hrvalid", 32'(host_rvalid), 32'd0);
    check("after_force_wcnt", 32'(dut.wcnt), 32'd0);
    tick();
    core_req = 1'b0;
    check("retry_rvalid", 32'(core_rvalid), 32'd1);
    check("retry_rdata", core_rdata, 32'hAAAA5555);
    tick();

    core_req   = 1'b1;
    core_we    = 4'b0100;
    core_addr  = 32'h50;
    core_wdata = 32'h00AB0000;
    tick();
    core_we = 4'h0;
    check("byte_wr_no_rvalid", 32'(core_rvalid), 32'd0);
    tick();
    core_req = 1'b0;
    check("byte_rd_rvalid", 32'(core_rvalid), 32'd1);
    check("byte_rd_rdata", core_rdata, 32'h11AB3344);
    tick();

    core_req   = 1'b1;
    core_addr  = 32'h10;
    host_valid = 1'b1;
    host_we    = 4'h0;
    host_addr  = 32'h20;
    #1;
    check("mid_rd_issue", 32'(core_stall), 32'd0);
    tick();
    rst     = 1'b1;
    core_we = 4'hF;
    #1;
    check("mid_rst_rvalid", 32'(core_rvalid), 32'd0);
    check("mid_rst_stall", 32'(core_stall), 32'd1);
    check("mid_rst_ready", 32'(host_ready), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    tick();
    idle_inputs();
    check("mid_rst_state", 32'(dut.state), 32'(CORE_PRI));
    check("mid_rst_wcnt", 32'(dut.wcnt), 32'd0);
    check("mid_rst_rvalid2", 32'(core_rvalid), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_rvalid", 32'(core_rvalid), 32'd0);
    check("post_rst_rdata", core_rdata, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares BRAM port B (the data-memory port) between the pipeline's LSU and an external host requester, such as a program loader or debug probe. Each cycle at most one access is issued to the BRAM. The core has priority, but a bounded-wait counter guarantees the host a slot. The block stalls the core when it loses arbitration and routes one-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- `HOST_MAX_WAIT`, default 8: cycles a pending host request may be refused before it is forced through (range 1..255).
- `CNT_W`, default 8: width of the wait counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req`  in  1  LSU access request (MEM stage load or store).
- `core_we`  in  4  byte write enables; 0 means read.
- `core_addr`  in  32  byte address.
- `core_wdata`  in  32  store data, already lane-aligned.
- `core_stall`  out  1  core must freeze the pipeline and hold its request.
- `core_rvalid`  out  1  pulse: `core_rdata` is valid.
- `core_rdata`  out  32  load word returned from the BRAM.
- `host_valid`  in  1  host request pending.
- `host_ready`  out  1  host request accepted this cycle.
- `host_we`  in  4  byte write enables; 0 means read.
- `host_addr`  in  32  byte address.
- `host_wdata`  in  32  write data.
- `host_rvalid`  out  1  pulse: `host_rdata` is valid.
- `host_rdata`  out  32  read word.
- `mem_we`  out  4  to BRAM `web`.
- `mem_addr`  out  32  to BRAM `addrb`.
- `mem_wdata`  out  32  to BRAM `dib`.
- `mem_rdata`  in  32  from BRAM `dob`; valid the cycle after the address is issued.

## Operation
- **States:**
  - `CORE_PRI` (reset state).
  - `HOST_FORCE`.
- **Grant in `CORE_PRI`:**
  - `core_req=1` grants the core.
  - Otherwise `host_valid=1` grants the host.
  - Otherwise idle.
- **Grant in `HOST_FORCE`:**
  - The host is granted when `host_valid=1`.
  - The core is granted only if `host_valid=0`.
- **Wait counter `wcnt`:**
  - Increments when `host_valid=1` and the host is not granted, saturating at `HOST_MAX_WAIT`.
  - Clears when the host is granted or `host_valid=0`.
- **Transitions:**
  - `CORE_PRI` to `HOST_FORCE` when the next-cycle `wcnt` reaches `HOST_MAX_WAIT`.
  - `HOST_FORCE` to `CORE_PRI` after one host grant, or when `host_valid` drops.
- **Issue:** the granted requester's `we`, `addr` and `wdata` are driven combinationally onto the `mem_*` outputs.
  - With no grant, `mem_we=0`, and `mem_addr`/`mem_wdata` follow the core inputs.
- **Handshakes:**
  - `core_stall = core_req & ~core_grant`.
  - `host_ready = host_grant`.
  - A host transfer completes on `host_valid & host_ready`.
  - The host must hold `valid`, `addr`, `we` and `wdata` stable until ready; dropping valid early is a protocol violation (assertion).
- **Read tag:** a registered tag {`rd_core`, `rd_host`} is set for an issued read (`we==0`).
  - In the next cycle the matching `*_rvalid` pulses and `*_rdata = mem_rdata`, registered through to the output.
  - Writes produce no rvalid.
- **Same-address conflict:** only the granted access occurs in a cycle. The loser issues later and observes the winner's write.

## Timing
- Grant is combinational, with zero-cycle decision latency.
- Read latency: issue in cycle N, `*_rvalid` in N+1.
- Writes commit at the edge ending the issue cycle.
- Back-to-back reads by either requester are allowed every cycle; tags pipeline one deep.
- Worst-case host wait is `HOST_MAX_WAIT`+1 cycles under continuous core traffic.
- Worst-case core stall is 1 cycle per forced host grant.
- Reset values:
  - State `CORE_PRI`, `wcnt` 0, tags 0.
  - `core_rvalid`=0, `host_rvalid`=0.
  - `core_rdata`=0, `host_rdata`=0.
  - During `rst`: `host_ready`=0, `mem_we`=0, `core_stall`=`core_req`.
- Reset mid-read: the pending tag is cleared and no rvalid pulse is emitted after reset.

## Structure
- The shared package `dmem_pkg` holds:
  - the state enumeration `CORE_PRI`/`HOST_FORCE`;
  - the `WE_NONE=4'b0000` constant;
  - the BRAM read-latency constant (1).
- One sub-module, `starve_counter`: saturating wait counter with `inc`, `clr` and a `sat` output, parameterised by `HOST_MAX_WAIT`.
- The arbiter FSM, issue mux and read-tag registers live in the top.

## Test plan
- **Core-only traffic:** `core_req=1`, `we=0`, `addr=0x10`, BRAM word 0xDEADBEEF -> `core_stall=0`; `core_rvalid=1` next cycle with `core_rdata=0xDEADBEEF`.
- **Host-only write then read:** host write `addr 0x20`, `we=4'hF`, data 0x12345678, then read 0x20 -> `host_ready=1` each cycle; `host_rvalid`, `host_rdata=0x12345678` one cycle after the read.
- **Starvation bound:** `core_req` held 1 continuously, `host_valid` asserted -> `host_ready` first rises exactly 9 cycles after `host_valid` with `HOST_MAX_WAIT=8`; `core_stall=1` in that cycle only.
- **Simultaneous write/read to 0x40:** host write of 0xAAAA5555 is forced while the core read is stalled -> the core's retried read returns 0xAAAA5555.
- **Reset mid-read:** core read issued, `rst=1` on the following edge -> `core_rvalid=0` afterwards, state `CORE_PRI`, `wcnt=0`.
- **Byte store:** core `we=4'b0100`, `wdata=0x00AB0000` onto a word holding 0x11223344, then read -> `core_rdata=0x11AB3344`.
